quadrilatero_rr_multigrant_arbiter: RTL and testbench
=====================================================

# quadrilatero_rr_multigrant_arbiter

Round-robin arbiter that grants up to NUM_GNT of WIDTH requesters per cycle. It reports each grant both as a one-hot vector and as per-slot indices, so a slot's index can drive that slot's mux select directly. The search pointer rotates only after BURST_LEN accepted grant cycles, and acceptance uses a downstream ready handshake. It sits between the quadrilatero row/operand requesters and the shared datapath slots, and is the parametrised successor of the fixed-burst row arbiter.

## Interface
- WIDTH, 8, number of requesters; legal range is WIDTH ≥ 2.
- NUM_GNT, 3, maximum grants per cycle (output slots); legal range is 1..WIDTH.
- BURST_LEN, 4, accepted grant cycles before the pointer rotates; legal range is ≥ 1.
- IDX_W, derived, equal to $clog2(WIDTH); not overridable.
- CNT_W, derived, equal to max(1, $clog2(BURST_LEN)); not overridable.
- clk_i  input  1  the single clock.
- rst_ni  input  1  reset; synchronous, active-low.
- req_i  input  WIDTH  request vector; bit i means requester i is requesting.
- ready_i  input  1  downstream accepts the current grant set this cycle.
- flush_i  input  1  synchronous clear of the pointer and burst counter.
- gnt_o  output  WIDTH  one-hot-per-requester grant vector.
- gnt_valid_o  output  NUM_GNT  slot k holds a grant.
- gnt_idx_o  output  NUM_GNT×IDX_W  requester index granted in slot k; 0 when the slot is not valid.
- ptr_o  output  IDX_W  current pointer (ptr_q).
- rotate_o  output  1  one-cycle pulse, high in the cycle an accepted grant causes rotation.

## Operation
- **State:** ptr_q (IDX_W bits) and cnt_q (CNT_W bits). There is no other storage.
- **Grant search (combinational):**
  - Scan indices ptr_q, ptr_q+1, … modulo WIDTH, covering exactly WIDTH positions.
  - The k-th requesting index found (k = 0..NUM_GNT-1) goes to slot k, with gnt_valid_o[k] = 1 and its gnt_o bit set.
  - The scan stops after NUM_GNT hits.
  - Unused slots have valid = 0 and idx = 0.
  - No requester is granted twice.
- **Acceptance:** `acc = ready_i && |req_i && rst_ni`. The grant set is ready-independent; ready_i affects state only.
- **On acc:**
  - If cnt_q == BURST_LEN-1:
    - cnt_q ← 0.
    - ptr_q ← (index in the last valid slot + 1) mod WIDTH.
    - rotate_o = 1.
  - Otherwise cnt_q ← cnt_q + 1 and ptr_q holds.
- **Partial slot fill:** rotation uses the last valid slot even when fewer than NUM_GNT slots are filled, which preserves fairness.
- **No acc:** ptr_q and cnt_q hold. With ready_i low the grant set stays stable while req_i is stable.
- **flush_i:** ptr_q ← 0 and cnt_q ← 0 on the next edge. It has priority over acc, and rotate_o stays 0 in that cycle.
- **Reset:**
  - While rst_ni is low, gnt_o, gnt_valid_o, gnt_idx_o and rotate_o are forced to 0.
  - At the edge: ptr_q ← 0, cnt_q ← 0, so ptr_o reads 0.
  - Reset mid-burst discards the partial count.
- **BURST_LEN = 1:** the block rotates on every accepted cycle.
- **Pointer wrap:** arithmetic is modulo WIDTH, including non-power-of-two WIDTH (compare against WIDTH-1, no bit truncation).

## Timing
- Grant outputs are combinational from req_i and ptr_q: zero-cycle latency.
- State updates on the rising clk_i edge after acc or flush_i. The new pointer affects grants from the following cycle.
- rotate_o is combinational, high in the cycle of the rotating acceptance.
- req_i changing while ready_i is low is legal; the grants follow it combinationally.

## Structure
- **Package `quadrilatero_arb_pkg`:** holds the IDX_W/CNT_W helper functions (clog2 with floor 1) and the slot typedef `struct {logic valid; logic [IDX_W-1:0] idx;}` as a parametrised helper function or type.
- **Sub-module `quadrilatero_rr_pick`:** purely combinational. It takes req and ptr and produces the slot array, gnt vector and last index. It is reusable by other arbiters.
- **Top module:** holds the counter/pointer registers, acceptance, flush and reset forcing.

## Test plan
All scenarios use WIDTH=8, NUM_GNT=3, BURST_LEN=4.
- **Reset:** req_i=0xFF with rst_ni low → gnt_o=0 and rotate_o=0. After release: gnt_o=0x07, idx {0,1,2}, ptr_o=0.
- **Burst rotation:** req_i=0xFF, ready_i=1.
  - Cycles 1–4: gnt_o=0x07, with rotate_o=1 in cycle 4.
  - Cycles 5–8: ptr=3, gnt_o=0x38.
  - After cycle 8: ptr=6, gnt_o=0xC1, idx {6,7,0}.
- **Stall:** req_i=0xFF, ready_i=0 for 10 cycles → gnt_o stays 0x07, ptr 0, no rotation. Then ready_i=1 → rotation after exactly 4 accepts.
- **Sparse request:** ptr=0, req_i=0x82 → slots {1,7} valid, slot 2 invalid, gnt_o=0x82. After 4 accepts ptr=0 ((7+1) mod 8).
- **Flush vs rotate:** cnt=3 with acc and flush_i both high → ptr=0, cnt=0, rotate_o=0.
- **Idle and mid-burst reset:** req_i=0 with ready_i=1 → cnt unchanged. With cnt=2, pulse rst_ni low for one edge → ptr=0, cnt=0, and the next rotation needs 4 accepts.

Source files
------------

// File: rtl/quadrilatero_arb_pkg.sv
// quadrilatero_arb_pkg
//   Shared helpers for the quadrilatero arbiters.
//   - clog2_f1(): ceil(log2(n)) with a floor of 1. It sizes index and counter
//     fields so that they stay at least one bit wide.
//   - slot_max_t / make_slot(): a grant slot (valid + requester index) at the
//     widest supported index width. Arbiters of any WIDTH can exchange slots
//     through it. Each arbiter also declares its own slot type at its exact
//     IDX_W.
package quadrilatero_arb_pkg;

  localparam int MAX_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } slot_max_t;

  function automatic int clog2_f1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic slot_max_t make_slot(input logic valid, input int unsigned idx);
    slot_max_t s;
    s.valid = valid;
    s.idx   = valid ? MAX_IDX_W'(idx) : '0;
    return s;
  endfunction

endpackage

// File: rtl/quadrilatero_rr_pick.sv
// quadrilatero_rr_pick
//   Purely combinational round-robin multi-grant picker. It scans the WIDTH
//   requesters starting at ptr_i and wrapping modulo WIDTH. The first NUM_GNT
//   requesting indices go into slots 0..NUM_GNT-1 in scan order.
// Ports
//   req_i        [WIDTH]           request vector
//   ptr_i        [IDX_W]           scan start index (must be < WIDTH)
//   gnt_o        [WIDTH]           granted requesters
//   slot_valid_o [NUM_GNT]         slot k holds a grant
//   slot_idx_o   [NUM_GNT][IDX_W]  requester index of slot k (0 if invalid)
//   last_idx_o   [IDX_W]           index held by the last valid slot
//   any_o                          at least one slot is valid
module quadrilatero_rr_pick
  import quadrilatero_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_GNT = 3,
  parameter int IDX_W   = clog2_f1(WIDTH)
) (
  input  logic [WIDTH-1:0]              req_i,
  input  logic [IDX_W-1:0]              ptr_i,
  output logic [WIDTH-1:0]              gnt_o,
  output logic [NUM_GNT-1:0]            slot_valid_o,
  output logic [NUM_GNT-1:0][IDX_W-1:0] slot_idx_o,
  output logic [IDX_W-1:0]              last_idx_o,
  output logic                          any_o
);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } slot_t;

  slot_t [NUM_GNT-1:0] slots;
  logic  [WIDTH-1:0]   req_rot;
  logic  [WIDTH-1:0]   gnt_rot;
  logic  [2*WIDTH-1:0] req_dbl;
  logic  [2*WIDTH-1:0] gnt_dbl;

  // Rotate the requests so that bit s is the requester at scan position s.
  // Doubling the vector avoids a modulo on every bit. It also handles
  // non-power-of-two WIDTH.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[WIDTH-1:0];

  always_comb begin
    int hits;
    int pos;
    slots      = '0;
    gnt_rot    = '0;
    last_idx_o = '0;
    hits       = 0;
    pos        = 0;
    for (int s = 0; s < WIDTH; s++) begin
      if (req_rot[s] && (hits < NUM_GNT)) begin
        pos = int'(ptr_i) + s;
        if (pos >= WIDTH) pos = pos - WIDTH;
        for (int k = 0; k < NUM_GNT; k++) begin
          if (k == hits) begin
            slots[k].valid = 1'b1;
            slots[k].idx   = IDX_W'(pos);
          end
        end
        gnt_rot[s] = 1'b1;
        last_idx_o = IDX_W'(pos);
        hits       = hits + 1;
      end
    end
  end

  // Rotate the grants back into requester order.
  assign gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
  assign gnt_o   = gnt_dbl[2*WIDTH-1:WIDTH];

  always_comb begin
    for (int k = 0; k < NUM_GNT; k++) begin
      slot_valid_o[k] = slots[k].valid;
      slot_idx_o[k]   = slots[k].idx;
    end
  end

  assign any_o = slots[0].valid;

endmodule

// File: rtl/quadrilatero_rr_multigrant_arbiter.sv
// quadrilatero_rr_multigrant_arbiter
//   Round-robin arbiter that grants up to NUM_GNT of WIDTH requesters per
//   cycle. The search pointer advances past the last granted requester. It
//   does so only after BURST_LEN accepted grant cycles. Grants are
//   combinational from req_i and the pointer. ready_i only decides whether
//   the cycle counts as accepted.
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset; it also forces grant outputs low
//   req_i        [WIDTH]          request vector
//   ready_i                       downstream accepts the current grant set
//   flush_i                       clear pointer and burst counter
//   gnt_o        [WIDTH]          granted requesters
//   gnt_valid_o  [NUM_GNT]        slot k holds a grant
//   gnt_idx_o    [NUM_GNT*IDX_W]  slot k index at bits [k*IDX_W +: IDX_W]
//   ptr_o        [IDX_W]          current search pointer
//   rotate_o                      accepted cycle that moves the pointer
module quadrilatero_rr_multigrant_arbiter
  import quadrilatero_arb_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_GNT   = 3,
  parameter  int BURST_LEN = 4,
  localparam int IDX_W     = clog2_f1(WIDTH),
  localparam int CNT_W     = clog2_f1(BURST_LEN)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH-1:0]         req_i,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         gnt_o,
  output logic [NUM_GNT-1:0]       gnt_valid_o,
  output logic [NUM_GNT*IDX_W-1:0] gnt_idx_o,
  output logic [IDX_W-1:0]         ptr_o,
  output logic                     rotate_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [WIDTH-1:0]              pick_gnt;
  logic [NUM_GNT-1:0]            pick_valid;
  logic [NUM_GNT-1:0][IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0]              pick_last;
  logic                          pick_any;
  logic                          acc;
  logic                          burst_end;

  quadrilatero_rr_pick #(
    .WIDTH  (WIDTH),
    .NUM_GNT(NUM_GNT),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i       (req_i),
    .ptr_i       (ptr_q),
    .gnt_o       (pick_gnt),
    .slot_valid_o(pick_valid),
    .slot_idx_o  (pick_idx),
    .last_idx_o  (pick_last),
    .any_o       (pick_any)
  );

  // Any request means at least one slot is filled. pick_any is therefore the
  // same as |req_i here.
  assign acc       = ready_i && pick_any && rst_ni;
  assign burst_end = (cnt_q == CNT_LAST);
  assign rotate_o  = acc && burst_end && !flush_i;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (acc) begin
      if (burst_end) begin
        cnt_d = '0;
        // Compare rather than truncate so that non-power-of-two WIDTH wraps correctly.
        ptr_d = (pick_last == IDX_LAST) ? '0 : pick_last + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign gnt_o       = rst_ni ? pick_gnt   : '0;
  assign gnt_valid_o = rst_ni ? pick_valid : '0;
  assign gnt_idx_o   = rst_ni ? pick_idx   : '0;
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_quadrilatero_rr_multigrant_arbiter.sv
module tb_quadrilatero_rr_multigrant_arbiter;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int B  = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    req;
  logic            ready;
  logic            flush;
  logic [W-1:0]    gnt;
  logic [N-1:0]    gvld;
  logic [N*IW-1:0] gidx;
  logic [IW-1:0]   ptr;
  logic            rot;

  int total = 0;
  int bad   = 0;

  // Reference state: pointer and burst count as plain integers.
  int m_ptr = 0;
  int m_cnt = 0;
  int m_last;
  logic [W-1:0]    e_gnt;
  logic [N-1:0]    e_vld;
  logic [N*IW-1:0] e_idx;
  logic            e_rot;
  logic            e_acc;

  always #5 clk = ~clk;

  quadrilatero_rr_multigrant_arbiter #(.WIDTH(W), .NUM_GNT(N), .BURST_LEN(B)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .ready_i    (ready),
    .flush_i    (flush),
    .gnt_o      (gnt),
    .gnt_valid_o(gvld),
    .gnt_idx_o  (gidx),
    .ptr_o      (ptr),
    .rotate_o   (rot)
  );

  // Walk the requesters in round-robin order from m_ptr and collect the
  // first N requesting ones into a queue.
  task automatic model_eval();
    int found[$];
    int pos;
    e_gnt  = '0;
    e_vld  = '0;
    e_idx  = '0;
    m_last = 0;
    for (int s = 0; s < W; s++) begin
      pos = (m_ptr + s) % W;
      if (req[pos] && found.size() < N) found.push_back(pos);
    end
    foreach (found[k]) begin
      e_gnt[found[k]]  = 1'b1;
      e_vld[k]         = 1'b1;
      e_idx[k*IW +: IW] = IW'(found[k]);
      m_last           = found[k];
    end
    e_acc = ready && (req != 0) && rst_n;
    e_rot = e_acc && (m_cnt == B - 1) && !flush;
    if (!rst_n) begin
      e_gnt = '0;
      e_vld = '0;
      e_idx = '0;
    end
  endtask

  // One clock edge. The reference state advances from the inputs present at the edge.
  task automatic step();
    int np, nc;
    model_eval();
    np = m_ptr;
    nc = m_cnt;
    if (!rst_n || flush) begin
      np = 0;
      nc = 0;
    end else if (e_acc) begin
      if (m_cnt == B - 1) begin
        nc = 0;
        np = (m_last + 1) % W;
      end else begin
        nc = m_cnt + 1;
      end
    end
    @(posedge clk);
    m_ptr = np;
    m_cnt = nc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; ready = 1'b1; flush = 1'b0;
    #2;
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    total++; if (rot !== 1'b0) begin bad++; $display("FAIL reset_rot got=%b exp=0", rot); end
    total++; if (gvld !== 3'b000 || gidx !== 9'd0) begin bad++; $display("FAIL reset_slots vld=%b idx=%h exp=0/0", gvld, gidx); end
    step();
    step();
    rst_n = 1'b1;
    #2;
    total++; if (gnt !== 8'h07) begin bad++; $display("FAIL post_reset_gnt got=%h exp=07", gnt); end
    total++; if (gidx !== 9'b010_001_000) begin bad++; $display("FAIL post_reset_idx got=%b exp=010001000", gidx); end
    total++; if (ptr !== 3'd0) begin bad++; $display("FAIL post_reset_ptr got=%0d exp=0", ptr); end
  endtask

  task automatic test_burst_rotation();
    req = 8'hFF; ready = 1'b1; flush = 1'b0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      total++; if (gnt !== 8'h07) begin bad++; $display("FAIL burst1_gnt c=%0d got=%h exp=07", c, gnt); end
      total++; if (rot !== (c == 4)) begin bad++; $display("FAIL burst1_rot c=%0d got=%b exp=%b", c, rot, (c == 4)); end
      step();
    end
    for (int c = 5; c <= 8; c++) begin
      total++; if (ptr !== 3'd3) begin bad++; $display("FAIL burst2_ptr c=%0d got=%0d exp=3", c, ptr); end
      total++; if (gnt !== 8'h38) begin bad++; $display("FAIL burst2_gnt c=%0d got=%h exp=38", c, gnt); end
      total++; if (rot !== (c == 8)) begin bad++; $display("FAIL burst2_rot c=%0d got=%b exp=%b", c, rot, (c == 8)); end
      step();
    end
    total++; if (ptr !== 3'd6) begin bad++; $display("FAIL burst3_ptr got=%0d exp=6", ptr); end
    total++; if (gnt !== 8'hC1) begin bad++; $display("FAIL burst3_gnt got=%h exp=C1", gnt); end
    total++; if (gidx !== 9'b000_111_110) begin bad++; $display("FAIL burst3_idx got=%b exp=000111110", gidx); end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_stall();
    req = 8'hFF; ready = 1'b0; flush = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      total++; if (gnt !== 8'h07) begin bad++; $display("FAIL stall_gnt c=%0d got=%h exp=07", c, gnt); end
      total++; if (ptr !== 3'd0) begin bad++; $display("FAIL stall_ptr c=%0d got=%0d exp=0", c, ptr); end
      total++; if (rot !== 1'b0) begin bad++; $display("FAIL stall_rot c=%0d got=%b exp=0", c, rot); end
      step();
    end
    ready = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      total++; if (rot !== (c == 4)) begin bad++; $display("FAIL stall_release_rot c=%0d got=%b exp=%b", c, rot, (c == 4)); end
      step();
    end
    total++; if (ptr !== 3'd3) begin bad++; $display("FAIL stall_release_ptr got=%0d exp=3", ptr); end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_sparse();
    req = 8'h82; ready = 1'b1; flush = 1'b0;
    #1;
    total++; if (gvld !== 3'b011) begin bad++; $display("FAIL sparse_vld got=%b exp=011", gvld); end
    total++; if (gnt !== 8'h82) begin bad++; $display("FAIL sparse_gnt got=%h exp=82", gnt); end
    total++; if (gidx !== 9'b000_111_001) begin bad++; $display("FAIL sparse_idx got=%b exp=000111001", gidx); end
    for (int c = 1; c <= 4; c++) begin
      total++; if (rot !== (c == 4)) begin bad++; $display("FAIL sparse_rot c=%0d got=%b exp=%b", c, rot, (c == 4)); end
      step();
    end
    total++; if (ptr !== 3'd0) begin bad++; $display("FAIL sparse_ptr got=%0d exp=0", ptr); end
    // Start from a non-zero pointer so the wrap to (7+1) mod 8 is visible.
    req = 8'hFF;
    for (int c = 0; c < 4; c++) step();
    req = 8'h82;
    #1;
    total++; if (gidx !== 9'b000_001_111) begin bad++; $display("FAIL sparse_wrap_idx got=%b exp=000001111", gidx); end
    for (int c = 0; c < 4; c++) step();
    total++; if (ptr !== 3'd2) begin bad++; $display("FAIL sparse_wrap_ptr got=%0d exp=2", ptr); end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_flush();
    req = 8'hFF; ready = 1'b1; flush = 1'b0;
    for (int c = 0; c < 7; c++) step();
    flush = 1'b1;
    #1;
    total++; if (rot !== 1'b0) begin bad++; $display("FAIL flush_rot got=%b exp=0", rot); end
    step();
    flush = 1'b0;
    #1;
    total++; if (ptr !== 3'd0) begin bad++; $display("FAIL flush_ptr got=%0d exp=0", ptr); end
    for (int c = 1; c <= 4; c++) begin
      total++; if (rot !== (c == 4)) begin bad++; $display("FAIL flush_cnt_rot c=%0d got=%b exp=%b", c, rot, (c == 4)); end
      step();
    end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_idle_and_reset();
    ready = 1'b1; flush = 1'b0; req = 8'hFF;
    step(); step();
    req = 8'h00;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (gnt !== 8'h00 || gvld !== 3'b000 || rot !== 1'b0) begin bad++; $display("FAIL idle_out c=%0d gnt=%h vld=%b rot=%b exp=00/000/0", c, gnt, gvld, rot); end
      step();
    end
    req = 8'hFF;
    #1;
    total++; if (rot !== 1'b0) begin bad++; $display("FAIL idle_cnt3_rot got=%b exp=0", rot); end
    step();
    total++; if (rot !== 1'b1) begin bad++; $display("FAIL idle_cnt_kept_rot got=%b exp=1", rot); end
    step();
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    total++; if (ptr !== 3'd0) begin bad++; $display("FAIL midreset_ptr got=%0d exp=0", ptr); end
    for (int c = 1; c <= 4; c++) begin
      total++; if (rot !== (c == 4)) begin bad++; $display("FAIL midreset_rot c=%0d got=%b exp=%b", c, rot, (c == 4)); end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req   = W'($urandom);
      if ($urandom_range(0, 3) == 0) req = req & W'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      #1;
      model_eval();
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rand_gnt c=%0d got=%h exp=%h", c, gnt, e_gnt); end
      total++; if (gvld !== e_vld) begin bad++; $display("FAIL rand_vld c=%0d got=%b exp=%b", c, gvld, e_vld); end
      total++; if (gidx !== e_idx) begin bad++; $display("FAIL rand_idx c=%0d got=%h exp=%h", c, gidx, e_idx); end
      total++; if (rot !== e_rot) begin bad++; $display("FAIL rand_rot c=%0d got=%b exp=%b", c, rot, e_rot); end
      total++; if (ptr !== IW'(m_ptr)) begin bad++; $display("FAIL rand_ptr c=%0d got=%0d exp=%0d", c, ptr, m_ptr); end
      step();
    end
    rst_n = 1'b1; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst_rotation();
    test_stall();
    test_sparse();
    test_flush();
    test_idle_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
